// File: rtl/par_to_ser_feeder.sv
// Parallel-to-serial feeder: takes a word over valid/ready and replays it as a
// serial bit stream with a contiguous shift-enable strobe for a downstream shift register.
module par_to_ser_feeder #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             word_done
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] PENULT   = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP_WAIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;

    // Bit 'idx' of the transmit order: counted from the MSB or from the LSB.
    function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                      input logic [CNT_W-1:0] idx);
        logic [WIDTH-1:0] aligned;
        if (MSB_FIRST != 0) begin
            aligned  = word << idx;
            pick_bit = aligned[WIDTH-1];
        end else begin
            aligned  = word >> idx;
            pick_bit = aligned[0];
        end
    endfunction

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            // NOTE: the shadow word is reset too, so a dropped word never leaks
            // into the next stream; it is a single register, not a memory array.
            shadow    <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ser_out   <= 1'b0;
            shift_en  <= 1'b0;
            word_done <= 1'b0;
        end else begin
            // NOTE: default first, later assignments in this block override it,
            // which is what makes word_done a single-cycle pulse.
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    // With GAP == 0 the last bit of a word is still on the line here.
                    if (bit_cnt == LAST_BIT) begin
                        word_done <= 1'b1;
                        shift_en  <= 1'b0;
                        ser_out   <= 1'b0;
                        bit_cnt   <= '0;
                    end
                    if (load_valid) begin
                        shadow   <= load_data;
                        ser_out  <= pick_bit(load_data, '0);
                        shift_en <= 1'b1;
                        bit_cnt  <= CNT_W'(1);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        shift_en  <= 1'b0;
                        ser_out   <= 1'b0;
                        word_done <= 1'b1;
                        bit_cnt   <= '0;
                        gap_cnt   <= '0;
                        state     <= GAP_WAIT;
                    end else begin
                        ser_out <= pick_bit(shadow, bit_cnt);
                        bit_cnt <= bit_cnt + 1'b1;
                        // Leaving early lets a new word be accepted on the edge that
                        // ends this word, keeping the strobe contiguous.
                        if (GAP == 0 && bit_cnt == PENULT) begin
                            state <= IDLE;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_par_to_ser_feeder.sv
// Bench for par_to_ser_feeder: four configurations, directed and random words,
// checked against a word-level stream model plus a model of the downstream left shift register.
module tb_par_to_ser_feeder;

    localparam int W     = 4;
    localparam int N_DUT = 4;

    typedef struct packed {
        logic sen;
        logic rdy;
        logic ser;
        logic wd;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] ld_data  [N_DUT];
    logic         ld_valid [N_DUT];
    wire          ld_ready [N_DUT];
    wire          ser      [N_DUT];
    wire          sen      [N_DUT];
    wire          bsy      [N_DUT];
    wire          wd       [N_DUT];

    int vectors    = 0;
    int miscompares = 0;

    // dut0: GAP=1 MSB first, dut1: GAP=0, dut2: GAP=3, dut3: GAP=1 LSB first
    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 3 : 1;
    endfunction
    function automatic bit msb_of(input int i);
        return (i == 3) ? 1'b0 : 1'b1;
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        par_to_ser_feeder #(
            .WIDTH    (W),
            .GAP      ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 1),
            .MSB_FIRST((g == 3) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .load_data (ld_data[g]),
            .load_valid(ld_valid[g]),
            .load_ready(ld_ready[g]),
            .ser_out   (ser[g]),
            .shift_en  (sen[g]),
            .busy      (bsy[g]),
            .word_done (wd[g])
        );
    end

    always #5 clk = ~clk;

    // One sample per cycle, taken just after the rising edge.
    smp_t trace_q [N_DUT][$];
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_DUT; i++)
            trace_q[i].push_back(smp_t'{sen[i], ld_ready[i], ser[i], wd[i]});
    end

    // Results of analysing a trace slice
    logic [127:0] got_v, exp_v;
    int           got_n, exp_n;
    int           n_wd, rdy_low, bad_wd, first_sen;
    logic [W-1:0] shreg;
    int           run_q[$], idle_q[$], wd_q[$];

    task automatic clear_exp();
        exp_v = '0;
        exp_n = 0;
    endtask

    task automatic add_exp(input logic [W-1:0] w, input bit msb);
        for (int k = 0; k < W; k++) begin
            exp_v = {exp_v[126:0], (msb ? w[W-1-k] : w[k])};
            exp_n++;
        end
    endtask

    task automatic collect(input int i, input int s);
        int  run, idle;
        bit  seen;
        smp_t t;
        got_v = '0; got_n = 0; n_wd = 0; rdy_low = 0; bad_wd = 0; first_sen = -1;
        shreg = '0; run = 0; idle = 0; seen = 1'b0;
        run_q.delete(); idle_q.delete(); wd_q.delete();
        for (int c = s; c < trace_q[i].size(); c++) begin
            t = trace_q[i][c];
            if (!t.rdy) rdy_low++;
            if (t.wd) begin
                n_wd++;
                wd_q.push_back(c);
                if (c == 0 || !trace_q[i][c-1].sen) bad_wd++;
                else if (c + 1 < trace_q[i].size() && trace_q[i][c+1].wd) bad_wd++;
            end
            if (t.sen) begin
                if (first_sen < 0) first_sen = c;
                got_v = {got_v[126:0], t.ser};
                got_n++;
                shreg = {shreg[W-2:0], t.ser};
                if (run == 0 && seen) idle_q.push_back(idle);
                run++;
                idle = 0;
            end else begin
                if (run > 0) begin
                    run_q.push_back(run);
                    run  = 0;
                    seen = 1'b1;
                end
                if (!t.rdy) idle++;
            end
        end
        if (run > 0) run_q.push_back(run);
    endtask

    // Present a word and hold it until it is accepted; returns on the negedge after the accept edge.
    task automatic send(input int i, input logic [W-1:0] w, input bit drop_valid);
        int waited;
        ld_data[i]  = w;
        ld_valid[i] = 1'b1;
        waited = 0;
        while (ld_ready[i] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            miscompares++;
            $display("FAIL accept_timeout dut%0d: load_ready stayed %b for %0d cycles, required 1", i, ld_ready[i], waited);
        end
        @(negedge clk);
        if (drop_valid) ld_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            vectors++;
            if ({ld_ready[i], bsy[i], ser[i], sen[i], wd[i]} !== 5'b10000) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: rdy,busy,ser,sen,wd=%b required 10000", i,
                         {ld_ready[i], bsy[i], ser[i], sen[i], wd[i]});
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int s = trace_q[0].size();
        send(0, 4'b1011, 1'b1);
        repeat (10) @(negedge clk);
        collect(0, s);
        clear_exp();
        add_exp(4'b1011, 1'b1);
        vectors++;
        if (got_n !== exp_n || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL single_stream: got %0d bits %h required %0d bits %h", got_n, got_v, exp_n, exp_v);
        end
        vectors++;
        if (run_q.size() !== 1 || run_q[0] !== 4) begin
            miscompares++;
            $display("FAIL single_strobe: got %0d runs, first %0d, required 1 run of 4", run_q.size(), run_q[0]);
        end
        vectors++;
        if (n_wd !== 1 || bad_wd !== 0) begin
            miscompares++;
            $display("FAIL single_word_done: got %0d pulses (%0d misplaced) required 1", n_wd, bad_wd);
        end
        vectors++;
        if (shreg !== 4'b1011) begin
            miscompares++;
            $display("FAIL single_shift_out: got %b required 1011", shreg);
        end
        vectors++;
        if (rdy_low !== 5) begin
            miscompares++;
            $display("FAIL single_ready_low: got %0d cycles required 5", rdy_low);
        end
    endtask

    task automatic test_back_to_back();
        int s = trace_q[1].size();
        send(1, 4'b1011, 1'b0);
        send(1, 4'b0110, 1'b1);
        repeat (8) @(negedge clk);
        collect(1, s);
        clear_exp();
        add_exp(4'b1011, 1'b1);
        add_exp(4'b0110, 1'b1);
        vectors++;
        if (got_n !== exp_n || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_stream: got %0d bits %h required %0d bits %h", got_n, got_v, exp_n, exp_v);
        end
        vectors++;
        if (run_q.size() !== 1 || run_q[0] !== 8) begin
            miscompares++;
            $display("FAIL b2b_strobe: got %0d runs, first %0d, required 1 run of 8", run_q.size(), run_q[0]);
        end
        vectors++;
        if (n_wd !== 2 || wd_q[0] - first_sen !== 4 || wd_q[1] - first_sen !== 8) begin
            miscompares++;
            $display("FAIL b2b_word_done: got %0d pulses at +%0d,+%0d required 2 at +4,+8",
                     n_wd, wd_q[0] - first_sen, wd_q[1] - first_sen);
        end
        vectors++;
        if (shreg !== 4'b0110) begin
            miscompares++;
            $display("FAIL b2b_shift_out: got %b required 0110", shreg);
        end
    endtask

    task automatic test_ignore_busy();
        int s = trace_q[0].size();
        send(0, 4'b1100, 1'b1);
        ld_data[0]  = 4'b0011;
        ld_valid[0] = 1'b1;
        @(negedge clk);
        ld_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        collect(0, s);
        clear_exp();
        add_exp(4'b1100, 1'b1);
        vectors++;
        if (got_n !== exp_n || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL ignore_stream: got %0d bits %h required %0d bits %h", got_n, got_v, exp_n, exp_v);
        end
        vectors++;
        if (n_wd !== 1 || shreg !== 4'b1100) begin
            miscompares++;
            $display("FAIL ignore_result: got %0d word_done, shift_out %b required 1, 1100", n_wd, shreg);
        end
    endtask

    task automatic test_reset_mid_word();
        int s = trace_q[0].size();
        int s2;
        send(0, 4'b1010, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({ld_ready[0], bsy[0], ser[0], sen[0], wd[0]} !== 5'b10000) begin
            miscompares++;
            $display("FAIL midreset_state: rdy,busy,ser,sen,wd=%b required 10000",
                     {ld_ready[0], bsy[0], ser[0], sen[0], wd[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        collect(0, s);
        vectors++;
        if (n_wd !== 0 || got_n !== 2 || got_v[1:0] !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_drop: got %0d word_done, %0d bits %b required 0, 2 bits 10", n_wd, got_n, got_v[1:0]);
        end
        s2 = trace_q[0].size();
        send(0, 4'b0101, 1'b1);
        repeat (10) @(negedge clk);
        collect(0, s2);
        clear_exp();
        add_exp(4'b0101, 1'b1);
        vectors++;
        if (got_n !== exp_n || got_v !== exp_v || shreg !== 4'b0101 || n_wd !== 1) begin
            miscompares++;
            $display("FAIL midreset_restart: got %0d bits %h shift_out %b wd %0d required %0d bits %h 0101 1",
                     got_n, got_v, shreg, n_wd, exp_n, exp_v);
        end
    endtask

    task automatic test_lsb_first();
        int s = trace_q[3].size();
        send(3, 4'b0001, 1'b1);
        repeat (10) @(negedge clk);
        collect(3, s);
        vectors++;
        if (got_n !== 4 || got_v[3:0] !== 4'b1000 || n_wd !== 1) begin
            miscompares++;
            $display("FAIL lsb_stream: got %0d bits %b wd %0d required 4 bits 1000 wd 1", got_n, got_v[3:0], n_wd);
        end
    endtask

    task automatic test_gap3();
        int s = trace_q[2].size();
        int bad = 0;
        send(2, 4'b1011, 1'b0);
        send(2, 4'b0110, 1'b0);
        send(2, 4'b1100, 1'b1);
        repeat (12) @(negedge clk);
        collect(2, s);
        clear_exp();
        add_exp(4'b1011, 1'b1);
        add_exp(4'b0110, 1'b1);
        add_exp(4'b1100, 1'b1);
        vectors++;
        if (got_n !== exp_n || got_v !== exp_v || n_wd !== 3) begin
            miscompares++;
            $display("FAIL gap3_stream: got %0d bits %h wd %0d required %0d bits %h wd 3", got_n, got_v, n_wd, exp_n, exp_v);
        end
        foreach (idle_q[k]) if (idle_q[k] != 3) bad++;
        foreach (run_q[k])  if (run_q[k] != 4) bad++;
        vectors++;
        if (idle_q.size() !== 2 || run_q.size() !== 3 || bad !== 0) begin
            miscompares++;
            $display("FAIL gap3_spacing: got %0d gaps %0d runs %0d off-size, required 2 gaps of 3, 3 runs of 4",
                     idle_q.size(), run_q.size(), bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < N_DUT; i++) begin
            int           s = trace_q[i].size();
            int           bad_run = 0;
            int           bad_gap = 0;
            logic [W-1:0] w, last_w;
            clear_exp();
            last_w = '0;
            for (int n = 0; n < 16; n++) begin
                w = W'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    ld_valid[i] = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                send(i, w, 1'b0);
                add_exp(w, msb_of(i));
                last_w = w;
            end
            ld_valid[i] = 1'b0;
            repeat (12) @(negedge clk);
            collect(i, s);
            vectors++;
            if (got_n !== exp_n || got_v !== exp_v) begin
                miscompares++;
                $display("FAIL random_stream dut%0d: got %0d bits %h required %0d bits %h", i, got_n, got_v, exp_n, exp_v);
            end
            vectors++;
            if (n_wd !== 16 || bad_wd !== 0) begin
                miscompares++;
                $display("FAIL random_word_done dut%0d: got %0d pulses (%0d misplaced) required 16", i, n_wd, bad_wd);
            end
            foreach (run_q[k])
                if ((gap_of(i) > 0 && run_q[k] != W) || run_q[k] % W != 0) bad_run++;
            foreach (idle_q[k])
                if (idle_q[k] != gap_of(i)) bad_gap++;
            vectors++;
            if (bad_run !== 0 || bad_gap !== 0) begin
                miscompares++;
                $display("FAIL random_shape dut%0d: got %0d bad strobe runs, %0d bad gaps, required 0, 0", i, bad_run, bad_gap);
            end
            if (msb_of(i)) begin
                vectors++;
                if (shreg !== last_w) begin
                    miscompares++;
                    $display("FAIL random_shift_out dut%0d: got %b required %b", i, shreg, last_w);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            ld_data[i]  = '0;
            ld_valid[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_word();
        test_lsb_first();
        test_gap3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
